dmem_responder: RTL and testbench

- Responder side of the processor's data-memory interface (address_dmem / data / wren / q_dmem).
- Serves word-addressed RAM plus a small MMIO window: a free-running cycle counter and a transmit FIFO drained through a valid/ready output port.
- Sits in Wrapper between the processor and the outside world, replacing the bare dmem instance.

---
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding a free-running
// cycle counter and a transmit FIFO drained over a valid/ready port.
module dmem_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        err_addr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [31:0] CNT_ADDR    = MMIO_BASE;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'd1;
  localparam logic [31:0] TXSTAT_ADDR = MMIO_BASE + 32'd2;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_RAM,
    SEL_MMIO
  } rd_sel_t;

  // Address decode
  logic hit_ram;
  logic hit_cnt;
  logic hit_txdata;
  logic hit_txstat;
  logic unmapped;

  assign hit_ram    = (address_dmem[31:ADDR_WIDTH] == '0);
  assign hit_cnt    = (address_dmem == CNT_ADDR);
  assign hit_txdata = (address_dmem == TXDATA_ADDR);
  assign hit_txstat = (address_dmem == TXSTAT_ADDR);
  assign unmapped   = ~(hit_ram | hit_cnt | hit_txdata | hit_txstat);

  // RAM: contents survive reset, and writes during reset still land
  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_q_p1;

  assign ram_idx = address_dmem[ADDR_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (wren && hit_ram) begin
      ram[ram_idx] <= data;
    end
    ram_q_p1 <= ram[ram_idx];
  end

  // Cycle counter
  logic [31:0] cyc_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else if (wren && hit_cnt) begin
      cyc_cnt <= data;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  // TX FIFO
  logic [31:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             overflow;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_req;
  logic             push;
  logic             pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign push_req   = wren & hit_txdata;
  assign pop        = ~fifo_empty & out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push       = push_req & (~fifo_full | pop);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (wren && hit_txstat && data[31]) begin
        overflow <= 1'b0;
      end
    end
  end

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];

  // MMIO read mux
  logic [31:0] txstat;
  logic [31:0] mmio_rd;
  rd_sel_t     rd_sel;

  always_comb begin
    txstat      = '0;
    txstat[7:0] = 8'(fifo_cnt);
    txstat[8]   = fifo_empty;
    txstat[9]   = fifo_full;
    txstat[31]  = overflow;
  end

  always_comb begin
    mmio_rd = '0;
    if (hit_cnt) begin
      mmio_rd = cyc_cnt;
    end else if (hit_txstat) begin
      mmio_rd = txstat;
    end
  end

  always_comb begin
    rd_sel = SEL_ZERO;
    if (hit_ram) begin
      rd_sel = SEL_RAM;
    end else if (hit_cnt || hit_txstat) begin
      rd_sel = SEL_MMIO;
    end
  end

  // Read stage: select is reset so q_dmem reads zero after reset
  rd_sel_t     rd_sel_p1;
  logic [31:0] mmio_q_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_sel_p1 <= SEL_ZERO;
    end else begin
      rd_sel_p1 <= rd_sel;
    end
    mmio_q_p1 <= mmio_rd;
  end

  always_comb begin
    q_dmem = '0;
    case (rd_sel_p1)
      SEL_RAM:  q_dmem = ram_q_p1;
      SEL_MMIO: q_dmem = mmio_q_p1;
      default:  q_dmem = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_addr <= 1'b0;
    end else if (wren && unmapped) begin
      err_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a queue/array model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_dmem_responder;

  localparam logic [31:0] BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] CNT_A  = BASE;
  localparam logic [31:0] TXD_A  = BASE + 32'd1;
  localparam logic [31:0] TXS_A  = BASE + 32'd2;
  localparam logic [31:0] IDLE_A = 32'h8000_0000;
  localparam logic [31:0] UNM_A  = 32'h0001_0000;
  localparam int          DEPTH  = 8;
  localparam int          RAMW   = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_dmem = IDLE_A;
  logic [31:0] data = 32'd0;
  logic        wren = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] q_dmem;
  logic        out_valid;
  logic [31:0] out_data;
  logic        err_addr;

  dmem_responder #(.ADDR_WIDTH(12), .FIFO_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
    .wren(wren), .q_dmem(q_dmem), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .err_addr(err_addr)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model
  logic [31:0] m_ram [int unsigned];
  logic [31:0] m_fifo [$];
  logic [31:0] m_q = 0;
  logic        m_known = 1'b0;
  logic [31:0] m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        m_err = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clock) begin : model
    logic [31:0] rd;
    logic        known;
    logic        do_pop;
    logic        was_full;
    int unsigned a;
    a = address_dmem;
    rd = 0;
    known = 1'b1;
    if (a < RAMW) begin
      known = m_ram.exists(a);
      rd = known ? m_ram[a] : 32'd0;
    end else if (address_dmem == CNT_A) begin
      rd = m_cnt;
    end else if (address_dmem == TXS_A) begin
      rd = {m_ovf, 21'd0, m_fifo.size() == DEPTH, m_fifo.size() == 0, 8'(m_fifo.size())};
    end
    if (wren && a < RAMW) m_ram[a] = data;
    if (reset) begin
      m_q = 0; m_known = 1'b1; m_cnt = 0; m_fifo.delete();
      m_ovf = 1'b0; m_err = 1'b0; chk_en = 1'b1;
    end else begin
      m_q = rd; m_known = known;
      m_cnt = (wren && address_dmem == CNT_A) ? data : m_cnt + 32'd1;
      do_pop = (m_fifo.size() != 0) && out_ready;
      was_full = (m_fifo.size() == DEPTH);
      if (do_pop) void'(m_fifo.pop_front());
      if (wren && address_dmem == TXD_A) begin
        if (!was_full || do_pop) m_fifo.push_back(data);
        else m_ovf = 1'b1;
      end
      if (wren && address_dmem == TXS_A && data[31]) m_ovf = 1'b0;
      if (wren && !(a < RAMW) && address_dmem != CNT_A && address_dmem != TXD_A
          && address_dmem != TXS_A) m_err = 1'b1;
    end
  end

  // Compare every cycle against the model
  always @(negedge clock) begin
    if (chk_en) begin
      if (m_known) check("model_q_dmem", q_dmem, m_q);
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_fifo.size() != 0});
      check("model_out_data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
      check("model_err_addr", {31'd0, err_addr}, {31'd0, m_err});
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    address_dmem = a; data = d; wren = w; out_ready = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic r);
    drive(IDLE_A, 32'd0, 1'b0, r);
  endtask

  initial begin
    logic [31:0] exp_seq [8];
    // Reset
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    check("rst_q_dmem", q_dmem, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_err_addr", {31'd0, err_addr}, 32'd0);
    reset = 1'b0;

    // Counter reads 10 after ten cycles out of reset
    repeat (10) idle(1'b0);
    drive(CNT_A, 32'd0, 1'b0, 1'b0);
    check("cnt_after_reset", q_dmem, 32'd10);

    // RAM path, read-first on collision
    drive(32'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    drive(32'd5, 32'd0, 1'b0, 1'b0);
    check("ram_read", q_dmem, 32'hDEADBEEF);
    drive(32'd5, 32'd1, 1'b1, 1'b0);
    check("ram_read_first", q_dmem, 32'hDEADBEEF);
    drive(32'd5, 32'd0, 1'b0, 1'b0);
    check("ram_new_word", q_dmem, 32'd1);
    drive(32'd7, 32'h1234_5678, 1'b1, 1'b0);

    // Counter load and wrap
    drive(CNT_A, 32'hFFFF_FFFE, 1'b1, 1'b0);
    drive(CNT_A, 32'd0, 1'b0, 1'b0);
    check("cnt_load", q_dmem, 32'hFFFF_FFFE);
    drive(CNT_A, 32'd0, 1'b0, 1'b0);
    check("cnt_max", q_dmem, 32'hFFFF_FFFF);
    drive(CNT_A, 32'd0, 1'b0, 1'b0);
    check("cnt_wrap", q_dmem, 32'd0);

    // Unmapped read
    drive(UNM_A, 32'd0, 1'b0, 1'b0);
    check("unmapped_read_q", q_dmem, 32'd0);
    check("unmapped_read_err", {31'd0, err_addr}, 32'd0);
    drive(TXD_A, 32'd0, 1'b0, 1'b0);
    check("txdata_read_q", q_dmem, 32'd0);

    // Overfill, then drain
    for (int i = 1; i <= 9; i++) drive(TXD_A, i, 1'b1, 1'b0);
    drive(TXS_A, 32'd0, 1'b0, 1'b0);
    check("txstat_full_ovf", q_dmem, 32'h8000_0208);
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", {31'd0, out_valid}, 32'd1);
      check("drain_data", out_data, i);
      idle(1'b1);
    end
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    check("drained_data", out_data, 32'd0);
    drive(TXS_A, 32'd0, 1'b0, 1'b0);
    check("txstat_empty", q_dmem, 32'h8000_0100);

    // Full FIFO with simultaneous push and pop, then overflow clear
    for (int i = 0; i < 8; i++) drive(TXD_A, 32'h11 + i, 1'b1, 1'b0);
    drive(TXD_A, 32'hAA, 1'b1, 1'b1);
    drive(TXS_A, 32'd0, 1'b0, 1'b0);
    check("txstat_push_pop_full", q_dmem, 32'h8000_0208);
    drive(TXS_A, 32'h8000_0000, 1'b1, 1'b0);
    drive(TXS_A, 32'd0, 1'b0, 1'b0);
    check("txstat_ovf_cleared", q_dmem, 32'h0000_0208);
    for (int i = 0; i < 7; i++) exp_seq[i] = 32'h12 + i;
    exp_seq[7] = 32'hAA;
    for (int i = 0; i < 8; i++) begin
      check("drain2_data", out_data, exp_seq[i]);
      idle(1'b1);
    end
    check("drain2_valid", {31'd0, out_valid}, 32'd0);

    // Empty FIFO: push with out_ready high does not fall through
    drive(TXD_A, 32'h55, 1'b1, 1'b1);
    check("nofall_valid", {31'd0, out_valid}, 32'd1);
    check("nofall_data", out_data, 32'h55);
    idle(1'b1);
    check("nofall_popped", {31'd0, out_valid}, 32'd0);

    // Unmapped write sets sticky error
    drive(UNM_A, 32'h1, 1'b1, 1'b0);
    check("unmapped_write_err", {31'd0, err_addr}, 32'd1);
    idle(1'b0);
    idle(1'b0);
    check("err_sticky", {31'd0, err_addr}, 32'd1);

    // Reset mid-stream with a RAM write in the reset cycle
    for (int i = 0; i < 3; i++) drive(TXD_A, 32'h70 + i, 1'b1, 1'b0);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    drive(32'd9, 32'hCAFE, 1'b1, 1'b1);
    reset = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_q", q_dmem, 32'd0);
    check("mid_rst_err", {31'd0, err_addr}, 32'd0);
    drive(CNT_A, 32'd0, 1'b0, 1'b0);
    check("mid_rst_cnt", q_dmem, 32'd0);
    drive(TXS_A, 32'd0, 1'b0, 1'b0);
    check("mid_rst_txstat", q_dmem, 32'h0000_0100);
    drive(32'd7, 32'd0, 1'b0, 1'b0);
    check("ram_kept", q_dmem, 32'h1234_5678);
    drive(32'd9, 32'd0, 1'b0, 1'b0);
    check("ram_write_in_reset", q_dmem, 32'hCAFE);
    idle(1'b0);

    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
